pwm_sequencer: RTL and testbench
================================

# pwm_sequencer

Programmable PWM pattern controller that sequences a prescaled timer through a small table of (period, hold, repeat) steps. It drives one PWM output. Each table step sets the period, duty and repeat count of the waveform, and the sequencer moves from step to step with no gap in the output. Host logic writes the table through a simple write port and controls runs with start/stop. The block sits alongside the fixed-rate dual timer and handles LED/indicator patterns that need runtime reconfiguration.

## Interface
- PRESCALE_TICKS, 600: clk cycles per timer tick (>=2).
- STEPS, 4: table entries; power of two, 2..16. AW = $clog2(STEPS).
- CW, 16: width of period and hold fields.
- IDLE_LEVEL, 0: output level when idle and during the inactive part of each period. The active level is ~IDLE_LEVEL.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- wr_en  in  1  write table entry wr_addr this cycle.
- wr_addr  in  AW  table index.
- wr_period  in  CW  period in ticks. A value of 0 is treated as 1.
- wr_hold  in  CW  active ticks per period.
- wr_reps  in  8  periods per step. A value of 0 marks end of sequence.
- start  in  1  begin a run at step 0. Sampled only in IDLE.
- stop  in  1  abort a run.
- loop  in  1  level; selects restart at step 0 instead of ending.
- out  out  1  PWM output, registered.
- busy  out  1  high in RUN.
- step_idx  out  AW  index of the active step.
- done  out  1  one-cycle pulse on normal sequence end.
- tick  out  1  one-cycle prescaler pulse; 0 outside RUN.

## Operation
- Reset values:
  - out=IDLE_LEVEL, busy=0, done=0, tick=0, step_idx=0.
  - Prescaler, phase and rep counters are 0.
  - All table entries are {0,0,0}.
- Table: STEPS x (CW+CW+8) register file. Writes are accepted in any state.
  - The working registers hold a copy of the active entry, so a write to the active entry takes effect only when that entry is next loaded.
- FSM has two states, IDLE and RUN.
  - IDLE, start=1, stop=0, entry0.reps!=0: load entry 0 into the working registers; clear prescaler, phase and rep; step_idx=0; go to RUN.
  - IDLE, start=1, stop=0, entry0.reps==0: done=1 next cycle; stay in IDLE.
  - RUN, stop=1: go to IDLE on the next edge; out=IDLE_LEVEL; no done pulse. If stop and start are both high, stop wins.
  - start is ignored while in RUN.
- Prescaler: counts 0..PRESCALE_TICKS-1 and wraps. tick=1 while the count equals PRESCALE_TICKS-1.
- On each tick:
  - phase advances. When phase equals P-1 (P = max(period,1)), phase wraps to 0 and rep increments.
  - When rep wraps at reps, the step ends.
- Step end, evaluated on the same edge:
  - next = step_idx+1. If step_idx = STEPS-1, next is treated as an end condition.
  - If next is valid and entry[next].reps!=0: load entry[next]; phase=0, rep=0.
  - Otherwise, if loop=1 and entry0.reps!=0: load entry 0.
  - Otherwise: go to IDLE, done=1 for one cycle, out=IDLE_LEVEL.
- Output: out = ~IDLE_LEVEL when the next-state phase is less than hold, else IDLE_LEVEL. It is registered, so it changes on the same edge as phase.
  - hold=0: out stays at IDLE_LEVEL.
  - hold>=P: out stays active for the whole step.

## Timing
- start high in cycle k: from cycle k+1, busy=1, step_idx=0, and out is active if hold0>0.
- The first tick is in cycle k+PRESCALE_TICKS. After that there is one tick every PRESCALE_TICKS cycles.
- Each period is exactly P*PRESCALE_TICKS cycles, and the active window is min(hold,P)*PRESCALE_TICKS cycles.
- Step changes, including loop wrap, take zero extra cycles. step_idx and out update on the edge ending the final tick.
- Sequence end: busy falls and done rises on the same edge; done lasts one cycle.
- A new start is accepted in the cycle after done.
- stop in cycle j: out=IDLE_LEVEL and busy=0 from cycle j+1.
- Reset asserted at any time forces the reset values immediately, without waiting for clk, and clears the table.

## Test plan
Bench parameters: PRESCALE_TICKS=4, STEPS=4, CW=8, IDLE_LEVEL=0.
- Single step: entry0 {P=5,H=2,R=3}, entry1 reps=0, start.
  - out is high 8 cycles, low 12 cycles, repeated 3 times.
  - busy stays high 60 cycles; done pulses at cycle start+61.
- Seamless steps: entry0 {4,1,1}, entry1 {2,2,2}, entry2 reps=0, start.
  - out: 4 high, 12 low, then 16 high continuously.
  - step_idx goes 0->1 at cycle 17; no glitch at the step boundary.
- Loop: all four entries valid, loop=1.
  - step_idx wraps 3->0 with no done pulse.
  - Drop loop: the run ends after step 3 with one done pulse.
  - A table write to step 2 during step 0 appears on the next pass through step 2.
- Stop: stop mid-period; stop together with start in IDLE.
  - Mid-period stop: out=0 and busy=0 the next cycle, no done.
  - Simultaneous stop+start in IDLE: the block stays idle.
  - A later start restarts at step 0, phase 0.
- Reset: assert reset asynchronously mid-run.
  - Outputs go to reset values before the next clk edge.
  - A subsequent start yields only a done pulse (table cleared).
- Edge values: hold=0 gives out constantly 0; hold=9 with P=5 gives out constantly 1; period=0 behaves as P=1 (4-cycle period).

Source files
------------

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: table-driven PWM pattern generator.
// A prescaled timer steps through a STEPS-entry table of (period, hold, reps)
// entries. Each entry produces `reps` PWM periods of `period` ticks, each with
// `hold` active ticks. Consecutive steps follow each other with no gap in the output.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_period/
//   wr_hold/wr_reps            table write port, accepted in any state
//   start, stop, loop          run control (stop wins over start; loop is a level)
//   out                        registered PWM output
//   busy, step_idx             run status and active table index
//   done                       one-cycle pulse when a sequence ends normally
//   tick                       one-cycle prescaler pulse, only while running
module pwm_sequencer #(
    parameter int unsigned PRESCALE_TICKS = 600,
    parameter int unsigned STEPS          = 4,
    parameter int unsigned CW             = 16,
    parameter logic        IDLE_LEVEL     = 1'b0,
    localparam int unsigned AW            = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_period,
    input  logic [CW-1:0] wr_hold,
    input  logic [7:0]    wr_reps,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic          out,
    output logic          busy,
    output logic [AW-1:0] step_idx,
    output logic          done,
    output logic          tick
);

    localparam int unsigned PW         = $clog2(PRESCALE_TICKS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_TICKS - 1);
    localparam logic [AW-1:0] IDX_FIRST  = '0;
    localparam logic [AW-1:0] IDX_LAST   = AW'(STEPS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] tbl_period [STEPS];
    logic [CW-1:0] tbl_hold   [STEPS];
    logic [7:0]    tbl_reps   [STEPS];

    logic [PW-1:0] presc, presc_nxt;
    logic [CW-1:0] phase, phase_nxt;
    logic [7:0]    rep, rep_nxt;
    logic [CW-1:0] cur_period, cur_period_nxt;
    logic [CW-1:0] cur_hold, cur_hold_nxt;
    logic [7:0]    cur_reps, cur_reps_nxt;
    logic [AW-1:0] step_nxt;
    logic          out_nxt, busy_nxt, done_nxt, tick_nxt;

    logic          tick_now, period_end, step_end;
    logic          next_ok, entry0_ok, wrap_ok, start_ok;
    logic [AW-1:0] idx_inc;
    logic          load;
    logic [AW-1:0] load_idx;

    // Table register file; cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_period[i] <= '0;
                tbl_hold[i]   <= '0;
                tbl_reps[i]   <= '0;
            end
        end else if (wr_en) begin
            tbl_period[wr_addr] <= wr_period;
            tbl_hold[wr_addr]   <= wr_hold;
            tbl_reps[wr_addr]   <= wr_reps;
        end
    end

    // Timer boundary and step-selection decode shared by both comb processes.
    always_comb begin
        idx_inc    = step_idx + AW'(1);
        tick_now   = (state == S_RUN) && (presc == PRESC_LAST);
        period_end = tick_now && (phase == cur_period - CW'(1));
        step_end   = period_end && (rep == cur_reps - 8'd1);
        next_ok    = (step_idx != IDX_LAST) && (tbl_reps[idx_inc] != 8'd0);
        entry0_ok  = (tbl_reps[IDX_FIRST] != 8'd0);
        wrap_ok    = loop && entry0_ok;
        start_ok   = (state == S_IDLE) && start && !stop;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok && entry0_ok) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (step_end && !next_ok && !wrap_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter, working-register and output next values.
    always_comb begin
        presc_nxt      = presc;
        phase_nxt      = phase;
        rep_nxt        = rep;
        step_nxt       = step_idx;
        cur_period_nxt = cur_period;
        cur_hold_nxt   = cur_hold;
        cur_reps_nxt   = cur_reps;
        done_nxt       = 1'b0;
        load           = 1'b0;
        load_idx       = IDX_FIRST;

        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    if (entry0_ok) begin
                        load      = 1'b1;
                        presc_nxt = '0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!stop) begin
                    presc_nxt = tick_now ? '0 : presc + PW'(1);
                    if (tick_now) begin
                        if (period_end) begin
                            phase_nxt = '0;
                            rep_nxt   = rep + 8'd1;
                            if (step_end) begin
                                if (next_ok) begin
                                    load     = 1'b1;
                                    load_idx = idx_inc;
                                end else if (wrap_ok) begin
                                    load = 1'b1;
                                end else begin
                                    done_nxt = 1'b1;
                                end
                            end
                        end else begin
                            phase_nxt = phase + CW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase

        // Working copy of the entry; a zero period runs as one tick.
        if (load) begin
            step_nxt       = load_idx;
            phase_nxt      = '0;
            rep_nxt        = '0;
            cur_period_nxt = (tbl_period[load_idx] == '0) ? CW'(1) : tbl_period[load_idx];
            cur_hold_nxt   = tbl_hold[load_idx];
            cur_reps_nxt   = tbl_reps[load_idx];
        end

        busy_nxt = (state_nxt == S_RUN);
        out_nxt  = (busy_nxt && (phase_nxt < cur_hold_nxt)) ? ~IDLE_LEVEL : IDLE_LEVEL;
        tick_nxt = busy_nxt && (presc_nxt == PRESC_LAST);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            phase      <= '0;
            rep        <= '0;
            cur_period <= CW'(1);
            cur_hold   <= '0;
            cur_reps   <= '0;
            step_idx   <= '0;
            out        <= IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick       <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            phase      <= phase_nxt;
            rep        <= rep_nxt;
            cur_period <= cur_period_nxt;
            cur_hold   <= cur_hold_nxt;
            cur_reps   <= cur_reps_nxt;
            step_idx   <= step_nxt;
            out        <= out_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            tick       <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: table-driven single-step cases,
// hand-written multi-cycle sequences and randomized runs, all compared
// every cycle against a cycle-counting model of the sequencer.
`timescale 1ns/1ps
module tb_pwm_sequencer;

    localparam int unsigned PT    = 4;
    localparam int unsigned STEPS = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_period;
    logic [CW-1:0] wr_hold;
    logic [7:0]    wr_reps;
    logic          start, stop, loop;
    logic          out, busy, done, tick;
    logic [AW-1:0] step_idx;

    always #5 clk = ~clk;

    pwm_sequencer #(
        .PRESCALE_TICKS(PT),
        .STEPS(STEPS),
        .CW(CW),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_period(wr_period),
        .wr_hold(wr_hold),
        .wr_reps(wr_reps),
        .start(start),
        .stop(stop),
        .loop(loop),
        .out(out),
        .busy(busy),
        .step_idx(step_idx),
        .done(done),
        .tick(tick)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int gcyc     = 0;

    // Inputs applied in the next cycle by step_cycle.
    logic          i_start = 0, i_stop = 0, i_loop = 0, i_we = 0;
    logic [AW-1:0] i_wa = '0;
    logic [7:0]    i_wp = '0, i_wh = '0, i_wr = '0;

    // Outputs sampled in the most recent cycle.
    logic          s_out, s_busy, s_done, s_tick;
    logic [AW-1:0] s_step;
    int            cnt_busy, cnt_high, cnt_done, done_at;

    // Reference model: per-step cycle counting from the table rules.
    int m_p[STEPS], m_h[STEPS], m_r[STEPS];
    bit m_run, m_done;
    int m_step, m_c, m_n, m_cp, m_ch, m_cr;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < STEPS; i++) begin
            m_p[i] = 0; m_h[i] = 0; m_r[i] = 0;
        end
        m_run = 0; m_done = 0; m_step = 0; m_c = 0; m_n = 0;
        m_cp = 1; m_ch = 0; m_cr = 0;
    endfunction

    function automatic void m_load(int i);
        m_step = i;
        m_c    = 0;
        m_cp   = (m_p[i] == 0) ? 1 : m_p[i];
        m_ch   = m_h[i];
        m_cr   = m_r[i];
    endfunction

    // Move the model to the next cycle given the inputs applied this cycle.
    function automatic void m_advance();
        bit dn = 0;
        if (!m_run) begin
            if (i_start && !i_stop) begin
                if (m_r[0] != 0) begin
                    m_load(0); m_run = 1; m_n = 0;
                end else begin
                    dn = 1;
                end
            end
        end else if (i_stop) begin
            m_run = 0;
        end else begin
            m_c++; m_n++;
            if (m_c == m_cp * m_cr * PT) begin
                if (m_step < STEPS - 1 && m_r[m_step + 1] != 0) m_load(m_step + 1);
                else if (i_loop && m_r[0] != 0) m_load(0);
                else begin m_run = 0; dn = 1; end
            end
        end
        if (i_we) begin
            m_p[i_wa] = int'(i_wp); m_h[i_wa] = int'(i_wh); m_r[i_wa] = int'(i_wr);
        end
        m_done = dn;
    endfunction

    // One clock: sample and check this cycle, apply inputs, advance the model.
    task automatic step_cycle();
        int eo, et, expv, actv;
        @(negedge clk);
        gcyc++;
        s_out = out; s_busy = busy; s_done = done; s_tick = tick; s_step = step_idx;
        eo   = (m_run && (((m_c / PT) % m_cp) < m_ch)) ? 1 : 0;
        et   = (m_run && ((m_n % PT) == PT - 1)) ? 1 : 0;
        expv = (eo << 3) | (int'(m_run) << 2) | (int'(m_done) << 1) | et;
        actv = (int'(out) << 3) | (int'(busy) << 2) | (int'(done) << 1) | int'(tick);
        chk($sformatf("cyc%0d {out,busy,done,tick}", gcyc), actv, expv);
        if (m_run) chk($sformatf("cyc%0d step_idx", gcyc), int'(step_idx), m_step);
        if (busy) cnt_busy++;
        if (out)  cnt_high++;
        if (done) begin cnt_done++; done_at = gcyc; end
        start = i_start; stop = i_stop; loop = i_loop;
        wr_en = i_we; wr_addr = i_wa; wr_period = i_wp; wr_hold = i_wh; wr_reps = i_wr;
        m_advance();
        i_start = 0; i_stop = 0; i_we = 0;
    endtask

    task automatic run_n(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic write_entry(input int a, input int p, input int h, input int r);
        i_we = 1; i_wa = AW'(a); i_wp = 8'(p); i_wh = 8'(h); i_wr = 8'(r);
        step_cycle();
    endtask

    typedef struct {
        int p;
        int h;
        int r;
        int exp_busy;
        int exp_high;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        vecs[0] = '{5, 2, 3, 60, 24};
        vecs[1] = '{5, 0, 2, 40, 0};
        vecs[2] = '{5, 9, 1, 20, 20};
        vecs[3] = '{0, 1, 2, 8, 8};
        vecs[4] = '{0, 0, 1, 4, 0};
        vecs[5] = '{3, 1, 2, 24, 8};
        vecs[6] = '{2, 5, 3, 24, 24};

        reset = 1; start = 0; stop = 0; loop = 0;
        wr_en = 0; wr_addr = '0; wr_period = '0; wr_hold = '0; wr_reps = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset out", int'(out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset step_idx", int'(step_idx), 0);
        chk("reset done", int'(done), 0);
        chk("reset tick", int'(tick), 0);
        #1 reset = 0;

        // Table-driven single-step cases.
        foreach (vecs[v]) begin
            write_entry(0, vecs[v].p, vecs[v].h, vecs[v].r);
            write_entry(1, 1, 1, 0);
            i_start = 1; step_cycle(); s0 = gcyc;
            cnt_busy = 0; cnt_high = 0; cnt_done = 0; done_at = 0;
            run_n(vecs[v].exp_busy + 3);
            chk($sformatf("vec%0d busy cycles", v), cnt_busy, vecs[v].exp_busy);
            chk($sformatf("vec%0d high cycles", v), cnt_high, vecs[v].exp_high);
            chk($sformatf("vec%0d done pulses", v), cnt_done, 1);
            chk($sformatf("vec%0d done offset", v), done_at - s0, vecs[v].exp_busy + 1);
        end

        // Seamless step change.
        write_entry(0, 4, 1, 1);
        write_entry(1, 2, 2, 2);
        write_entry(2, 1, 1, 0);
        i_start = 1; step_cycle();
        for (int n = 1; n <= 35; n++) begin
            step_cycle();
            if (n == 1)  begin chk("seam n1 busy", int'(s_busy), 1); chk("seam n1 out", int'(s_out), 1); end
            if (n == 16) begin chk("seam n16 out", int'(s_out), 0); chk("seam n16 step", int'(s_step), 0); end
            if (n == 17) begin chk("seam n17 out", int'(s_out), 1); chk("seam n17 step", int'(s_step), 1); end
            if (n == 32) chk("seam n32 busy", int'(s_busy), 1);
            if (n == 33) begin chk("seam n33 done", int'(s_done), 1); chk("seam n33 busy", int'(s_busy), 0); end
        end

        // Loop, table update on a later pass, then loop dropped.
        write_entry(0, 2, 1, 1);
        write_entry(1, 1, 1, 1);
        write_entry(2, 3, 2, 1);
        write_entry(3, 1, 0, 2);
        i_loop = 1;
        i_start = 1; step_cycle(); cnt_done = 0;
        for (int n = 1; n <= 92; n++) begin
            if (n == 35) begin i_we = 1; i_wa = 2'd2; i_wp = 8'd2; i_wh = 8'd0; i_wr = 8'd1; end
            if (n == 65) i_loop = 0;
            step_cycle();
            if (n == 13) chk("loop n13 out", int'(s_out), 1);
            if (n == 32) chk("loop n32 step", int'(s_step), 3);
            if (n == 33) begin chk("loop n33 step", int'(s_step), 0); chk("loop n33 done", int'(s_done), 0); end
            if (n == 45) begin chk("loop n45 step", int'(s_step), 2); chk("loop n45 out", int'(s_out), 0); end
            if (n == 89) begin chk("loop n89 done", int'(s_done), 1); chk("loop n89 busy", int'(s_busy), 0); end
        end
        chk("loop done pulses", cnt_done, 1);

        // Stop mid-period, stop+start in idle, restart.
        write_entry(0, 5, 2, 3);
        write_entry(1, 1, 1, 0);
        i_start = 1; step_cycle(); cnt_done = 0;
        run_n(6);
        chk("stop pre out", int'(s_out), 1);
        i_stop = 1; step_cycle();
        step_cycle();
        chk("stop out", int'(s_out), 0);
        chk("stop busy", int'(s_busy), 0);
        run_n(3);
        i_start = 1; i_stop = 1; step_cycle();
        step_cycle();
        chk("start+stop busy", int'(s_busy), 0);
        run_n(2);
        chk("stop done pulses", cnt_done, 0);
        i_start = 1; step_cycle();
        step_cycle();
        chk("restart busy", int'(s_busy), 1);
        chk("restart step", int'(s_step), 0);
        chk("restart out", int'(s_out), 1);
        run_n(3);
        chk("restart first tick", int'(s_tick), 1);
        i_stop = 1; step_cycle();
        run_n(2);

        // Asynchronous reset mid-run.
        write_entry(0, 1, 1, 1);
        write_entry(1, 2, 1, 1);
        i_loop = 1;
        i_start = 1; step_cycle();
        run_n(6);
        chk("prereset step", int'(s_step), 1);
        #1 reset = 1;
        #1;
        chk("async reset out", int'(out), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset step", int'(step_idx), 0);
        chk("async reset tick", int'(tick), 0);
        #1 reset = 0;
        m_reset();
        i_loop = 0;
        i_start = 1; step_cycle();
        step_cycle();
        chk("cleared start done", int'(s_done), 1);
        chk("cleared start busy", int'(s_busy), 0);
        step_cycle();
        chk("cleared done width", int'(s_done), 0);

        // Randomized runs against the model.
        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < STEPS; a++)
                write_entry(a, $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3));
            i_loop = ($urandom_range(0, 2) == 0);
            i_start = 1; step_cycle();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    i_we = 1; i_wa = AW'($urandom_range(0, STEPS - 1));
                    i_wp = 8'($urandom_range(0, 4)); i_wh = 8'($urandom_range(0, 5));
                    i_wr = 8'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 49) == 0) i_loop = !i_loop;
                if ($urandom_range(0, 29) == 0) i_start = 1;
                if ($urandom_range(0, 199) == 0) i_stop = 1;
                step_cycle();
                if (c > 2 && !m_run && !m_done) break;
            end
            i_stop = 1; step_cycle();
            run_n(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
